rx_buf_demux: RTL
=================

RX_BUF_DEMUX -- requirements
Module: rx_buf_demux

Interface
REQ-001 Parameter NET_MIN, default 8: minimum netq free entries needed to accept a network frame start.
REQ-002 Parameter PAUSE_THRES, default 16: netq free-entry level below which pause_req asserts.
REQ-003 clk  input  1  rising-edge clock for all logic.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 rx_valid  input  1  rx_hdr/rx_data hold a valid 66b block this cycle.
REQ-006 rx_hdr  input  2  sync header: 2'b10 = data block, 2'b01 = control block; other values are invalid.
REQ-007 rx_data  input  64  block payload; for control blocks, rx_data[7:0] is the type byte.
REQ-008 memq_full  input  1  memory-response queue cannot accept a write.
REQ-009 reqq_full  input  1  request queue cannot accept a write.
REQ-010 netq_space  input  6  network queue free entries.
REQ-011 memq_wr / memq_din  output  1 / 64  memory-response queue write strobe and data.
REQ-012 reqq_wr / reqq_din  output  1 / 56  request queue write strobe and data.
REQ-013 netq_wr / netq_din  output  1 / 66  network queue write strobe and data ({hdr, data}).
REQ-014 pause_req  output  1  asks the link partner to stop network traffic.
REQ-015 drop_cnt, req_drop_cnt, err_cnt  output  16 each  saturating event counters.

Function
REQ-016 Type bytes: 0x1E idle, 0x66 request, 0x55 memory-response start, 0x78 network start, 0x87 terminate; any other control type is a protocol error.
REQ-017 FSM states: IDLE, MEM, NET, DROP; state changes only on cycles with rx_valid=1.
REQ-018 All queue outputs are registered: exactly 1 cycle from input block to wr strobe; each wr strobe is high for one cycle per written block.
REQ-019 Idle blocks are never written and never change state.
REQ-020 Request (0x66) is accepted in every state without changing state: reqq_din = rx_data[63:8] when reqq_full=0; when reqq_full=1, no write and req_drop_cnt increments.
REQ-021 IDLE + 0x55 -> MEM; the 0x55 block itself is not written.
REQ-022 MEM + data block -> memq_din = rx_data when memq_full=0; when memq_full=1 -> DROP, drop_cnt increments, no write.
REQ-023 MEM + 0x87 -> IDLE; the terminate block is not written.
REQ-024 IDLE + 0x78 with netq_space >= NET_MIN -> NET, start block written to netq.
REQ-025 IDLE + 0x78 with netq_space < NET_MIN -> DROP, drop_cnt increments.
REQ-026 NET: data blocks and the terminate block are written to netq as {rx_hdr, rx_data}; 0x87 -> IDLE after writing.
REQ-027 NET with netq_space == 0 on an incoming data block -> no write, DROP, drop_cnt increments, err_cnt increments.
REQ-028 DROP: all data blocks are discarded; 0x87 -> IDLE.
REQ-029 Any data block in IDLE increments err_cnt and is discarded.
REQ-030 Any unknown control type or invalid rx_hdr increments err_cnt, is discarded, and leaves the state unchanged.
REQ-031 0x55 or 0x78 received in MEM, NET or DROP: err_cnt increments and the block is handled as if received in IDLE (frame restart).
REQ-032 Counters saturate at 16'hFFFF; when one block triggers two increments of the same counter, that counter advances by 1.
REQ-033 pause_req is registered: 1 when netq_space < PAUSE_THRES, else 0; it is evaluated every cycle, independent of rx_valid.
REQ-034 rx_valid=0: no writes, no counter or state change.

Reset
REQ-035 Asserting reset at any time, including mid-frame, forces: state IDLE, all wr strobes 0, all din 0, pause_req 0, all counters 0.
REQ-036 The first block after reset deassertion is interpreted in IDLE; a partial frame in flight at reset is treated per REQ-029.

Verification
REQ-037 0x55, 3 data blocks (A, B, C), 0x87 with memq_full=0 -> memq_wr pulses 3 cycles, each one cycle after its input, carrying A, B, C; state returns to IDLE.
REQ-038 0x78 (netq_space=20), 2 data blocks, 0x87 -> netq_wr 4 times, netq_din[65:64] = 01, 10, 10, 01; drop_cnt=0.
REQ-039 0x78 with netq_space=5 -> no netq_wr for the whole frame; drop_cnt=1; next 0x78 with space=20 is accepted.
REQ-040 NET frame with 0x66 (payload 56'h1234) inserted mid-frame -> reqq_din=56'h1234, and netq receives the frame blocks contiguously, without the request block.
REQ-041 memq_full=1 on the 2nd data block of a MEM frame -> 1 write, drop_cnt=1, remaining blocks discarded, IDLE after 0x87.
REQ-042 Reset mid-NET frame, then a data block -> err_cnt=1, no writes; netq_space sweeps 17 -> 15 -> pause_req goes 0 -> 1 one cycle later.

Source files
------------

// File: rtl/rx_buf_demux.sv
// rx_buf_demux
// Steers incoming 66b blocks into three queues: memory-response frames
// (0x55 ... 0x87) go to memq, request blocks (0x66) go to reqq in any
// state, and network frames (0x78 ... 0x87) go to netq with their sync
// header. Drops and protocol errors are tallied in saturating counters,
// and pause_req warns the link partner when netq is running low.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   rx_valid              rx_hdr/rx_data carry a block this cycle
//   rx_hdr[1:0]           2'b10 data, 2'b01 control, others invalid
//   rx_data[63:0]         payload; control type byte in [7:0]
//   memq_full/reqq_full   downstream queue full flags
//   netq_space[5:0]       free netq entries
//   memq_wr/memq_din      memory-response queue write (64b)
//   reqq_wr/reqq_din      request queue write (56b)
//   netq_wr/netq_din      network queue write ({hdr, data}, 66b)
//   pause_req             registered netq low-water flag
//   drop_cnt, req_drop_cnt, err_cnt  saturating event counters
module rx_buf_demux #(
    parameter int unsigned NET_MIN     = 8,
    parameter int unsigned PAUSE_THRES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [1:0]  rx_hdr,
    input  logic [63:0] rx_data,
    input  logic        memq_full,
    input  logic        reqq_full,
    input  logic [5:0]  netq_space,
    output logic        memq_wr,
    output logic [63:0] memq_din,
    output logic        reqq_wr,
    output logic [55:0] reqq_din,
    output logic        netq_wr,
    output logic [65:0] netq_din,
    output logic        pause_req,
    output logic [15:0] drop_cnt,
    output logic [15:0] req_drop_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [7:0] T_IDLE = 8'h1E;
    localparam logic [7:0] T_REQ  = 8'h66;
    localparam logic [7:0] T_MEM  = 8'h55;
    localparam logic [7:0] T_NET  = 8'h78;
    localparam logic [7:0] T_TERM = 8'h87;

    localparam logic [6:0] NET_MIN_W = 7'(NET_MIN);
    localparam logic [6:0] PAUSE_W   = 7'(PAUSE_THRES);

    typedef enum logic [1:0] {IDLE, MEM, NET, DROP} state_t;

    state_t state_q, state_d;

    logic is_data, is_ctrl, space_ok;
    logic [7:0] rx_type;
    logic mem_wr_d, req_wr_d, net_wr_d;
    logic drop_inc, req_drop_inc, err_inc;

    assign is_data  = (rx_hdr == 2'b10);
    assign is_ctrl  = (rx_hdr == 2'b01);
    assign rx_type  = rx_data[7:0];
    assign space_ok = ({1'b0, netq_space} >= NET_MIN_W);

    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic inc);
        return (inc && (c != '1)) ? c + 16'd1 : c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        mem_wr_d     = 1'b0;
        req_wr_d     = 1'b0;
        net_wr_d     = 1'b0;
        drop_inc     = 1'b0;
        req_drop_inc = 1'b0;
        err_inc      = 1'b0;
        if (rx_valid) begin
            if (is_data) begin
                unique case (state_q)
                    IDLE: err_inc = 1'b1;
                    MEM: begin
                        if (memq_full) begin
                            drop_inc = 1'b1;
                            state_d  = DROP;
                        end else begin
                            mem_wr_d = 1'b1;
                        end
                    end
                    NET: begin
                        if (netq_space == '0) begin
                            drop_inc = 1'b1;
                            err_inc  = 1'b1;
                            state_d  = DROP;
                        end else begin
                            net_wr_d = 1'b1;
                        end
                    end
                    DROP: ;
                    default: ;
                endcase
            end else if (is_ctrl) begin
                case (rx_type)
                    T_IDLE: ;
                    T_REQ: begin
                        if (reqq_full) req_drop_inc = 1'b1;
                        else           req_wr_d     = 1'b1;
                    end
                    // Frame starts restart from IDLE regardless of the current frame.
                    T_MEM: begin
                        err_inc = (state_q != IDLE);
                        state_d = MEM;
                    end
                    T_NET: begin
                        err_inc = (state_q != IDLE);
                        if (space_ok) begin
                            state_d  = NET;
                            net_wr_d = 1'b1;
                        end else begin
                            state_d  = DROP;
                            drop_inc = 1'b1;
                        end
                    end
                    T_TERM: begin
                        net_wr_d = (state_q == NET);
                        state_d  = IDLE;
                    end
                    default: err_inc = 1'b1;
                endcase
            end else begin
                err_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memq_wr      <= 1'b0;
            memq_din     <= '0;
            reqq_wr      <= 1'b0;
            reqq_din     <= '0;
            netq_wr      <= 1'b0;
            netq_din     <= '0;
            pause_req    <= 1'b0;
            drop_cnt     <= '0;
            req_drop_cnt <= '0;
            err_cnt      <= '0;
        end else begin
            memq_wr   <= mem_wr_d;
            reqq_wr   <= req_wr_d;
            netq_wr   <= net_wr_d;
            if (mem_wr_d) memq_din <= rx_data;
            if (req_wr_d) reqq_din <= rx_data[63:8];
            if (net_wr_d) netq_din <= {rx_hdr, rx_data};
            pause_req    <= ({1'b0, netq_space} < PAUSE_W);
            drop_cnt     <= sat_inc(drop_cnt, drop_inc);
            req_drop_cnt <= sat_inc(req_drop_cnt, req_drop_inc);
            err_cnt      <= sat_inc(err_cnt, err_inc);
        end
    end

endmodule
